// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter that shares the single FIFO write port among NREQ requesters
module fifo_write_arbiter #(
   parameter int SIZE  = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4
) (
   input  logic                   w_clk,
   input  logic                   n_rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*SIZE-1:0]   req_data,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        grant,
   output logic                   valid_write,
   output logic [SIZE-1:0]        wr_data,
   input  logic                   f_flag,
   input  logic                   almost_full_flag
);
   localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, STALL = 2'd2;
   logic [1:0]      fsm;
   logic [PW-1:0]   rr_ptr, g, sel, idx, nxt;
   logic [3:0]      cnt;
   logic            full, issue, last;
   assign full  = f_flag | almost_full_flag;
   assign issue = (fsm == GRANT) & req[g] & ~full & n_rst;
   assign ack   = issue ? NREQ'(1) << g : '0;
   assign last  = cnt + 4'd1 == 4'(BURST);
   assign nxt   = PW'((int'(g) + 1) % NREQ);
   // lowest offset from rr_ptr wins, so scan offsets downwards and keep the last hit
   always_comb begin
      sel = rr_ptr;
      idx = rr_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr) + k) % NREQ);
         if (req[idx]) sel = idx;
      end
   end
   always_ff @(posedge w_clk) begin
      if (!n_rst) begin
         fsm         <= IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         g           <= '0;
         valid_write <= 1'b0;
         wr_data     <= '0;
      end else begin
         valid_write <= issue;
         if (issue) begin
            wr_data <= req_data[int'(g)*SIZE +: SIZE];
            cnt     <= cnt + 4'd1;
         end
         if (fsm == IDLE) begin
            if (|req) begin
               g     <= sel;
               grant <= NREQ'(1) << sel;
               cnt   <= '0;
               fsm   <= GRANT;
            end
         end else if (!req[g] || (issue && last)) begin
            rr_ptr <= nxt;
            grant  <= '0;
            fsm    <= IDLE;
         end else if (fsm == GRANT && full) begin
            fsm <= STALL;
         end else if (fsm == STALL && !full) begin
            fsm <= GRANT;
         end
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios plus random traffic against a behavioural owner/burst model
module tb_fifo_write_arbiter;
   localparam int SIZE = 8, NREQ = 4, BURST = 4;
   logic                 w_clk = 1'b0;
   logic                 n_rst, f_flag, almost_full_flag, valid_write;
   logic [NREQ-1:0]      req, ack, grant;
   logic [NREQ*SIZE-1:0] req_data;
   logic [SIZE-1:0]      wr_data;

   fifo_write_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .BURST(BURST)) dut (
      .w_clk(w_clk), .n_rst(n_rst), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
      .valid_write(valid_write), .wr_data(wr_data), .f_flag(f_flag), .almost_full_flag(almost_full_flag)
   );

   always #5 w_clk = ~w_clk;

   logic [SIZE-1:0] q[NREQ][$];
   logic [SIZE-1:0] wlog[$];
   int              wcyc[$];
   int              n_chk = 0, n_fail = 0, cyc = 0;
   bit              chk_en = 0;
   logic [NREQ-1:0] ack_cap;
   // model: owner index (-1 = nobody), next search start, words in current burst, stalled
   int              m_own = -1, m_ptr = 0, m_words = 0;
   bit              m_stall = 0, m_vw = 0;
   logic [SIZE-1:0] m_wd = '0;

   function automatic bit m_issue();
      return n_rst === 1'b1 && m_own >= 0 && !m_stall && req[m_own] === 1'b1 && !f_flag && !almost_full_flag;
   endfunction

   function automatic logic [NREQ-1:0] onehot(int i);
      return i < 0 ? '0 : NREQ'(1) << i;
   endfunction

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += q[i].size();
      return s;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge w_clk) begin
      ack_cap = ack;
      if (valid_write === 1'b1) begin
         wlog.push_back(wr_data);
         wcyc.push_back(cyc);
      end
      if (chk_en) begin
         check("ack", ack, m_issue() ? onehot(m_own) : '0);
         check("grant", grant, onehot(m_own));
         check("valid_write", valid_write, m_vw);
         check("wr_data", wr_data, m_wd);
      end
   end

   task automatic m_step();
      bit iss = m_issue();
      if (n_rst !== 1'b1) begin
         m_own = -1; m_ptr = 0; m_words = 0; m_stall = 0; m_vw = 0; m_wd = '0;
         return;
      end
      m_vw = iss;
      if (iss) begin
         m_wd = req_data[m_own*SIZE +: SIZE];
         m_words++;
      end
      if (m_own < 0) begin
         for (int k = 0; k < NREQ; k++)
            if (m_own < 0 && req[(m_ptr + k) % NREQ]) m_own = (m_ptr + k) % NREQ;
         m_words = 0;
         m_stall = 0;
      end else if (!req[m_own] || m_words == BURST) begin
         m_ptr = (m_own + 1) % NREQ;
         m_own = -1;
      end else begin
         m_stall = f_flag || almost_full_flag;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = q[i].size() != 0;
         req_data[i*SIZE +: SIZE] = q[i].size() != 0 ? q[i][0] : '0;
      end
   endtask

   task automatic tick();
      @(posedge w_clk);
      m_step();
      for (int i = 0; i < NREQ; i++)
         if (ack_cap[i] === 1'b1 && q[i].size() != 0) void'(q[i].pop_front());
      cyc++;
      #1 drive();
   endtask

   task automatic load(int i, int base, int n);
      for (int k = 0; k < n; k++) q[i].push_back(SIZE'(base + k));
      drive();
   endtask

   task automatic run_idle(int budget);
      int b = budget;
      while (b > 0 && (pending() != 0 || m_own >= 0)) begin
         tick();
         b--;
      end
      tick();
      check("drain", pending() + (m_own >= 0 ? 1 : 0), 0);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      wlog.delete();
      wcyc.delete();
   endtask

   initial begin
      int s, n, hits;
      n_rst = 1'b0; f_flag = 1'b0; almost_full_flag = 1'b0;
      for (int i = 0; i < NREQ; i++) load(i, 'hA0 + i, 1);
      tick();
      chk_en = 1;
      repeat (3) begin
         @(negedge w_clk);
         check("rst_ack", ack, 0);
         check("rst_grant", grant, 0);
         check("rst_vw", valid_write, 0);
         check("rst_wd", wr_data, 0);
         tick();
      end
      n_rst = 1'b1;
      @(negedge w_clk); check("t1_idle_grant", grant, 0);
      tick(); @(negedge w_clk); check("t1_first_grant", grant, 4'b0001); check("t1_first_ack", ack, 4'b0001);
      tick(); @(negedge w_clk); check("t1_first_vw", valid_write, 1); check("t1_first_wd", wr_data, 'hA0);
      run_idle(100);

      wlog.delete(); wcyc.delete();
      load(1, 'h10, 6);
      run_idle(100);
      check("t2_nwrites", wlog.size(), 6);
      if (wlog.size() == 6)
         for (int k = 0; k < 6; k++) begin
            check("t2_word", wlog[k], 'h10 + k);
            if (k > 0) check("t2_spacing", wcyc[k] - wcyc[k-1], k == 4 ? 2 : 1);
         end
      load(0, 'h20, 1); load(2, 'h22, 1);
      tick(); @(negedge w_clk); check("t2_rr_ptr", grant, 4'b0100);
      run_idle(100);

      do_reset();
      s = cyc;
      for (int i = 0; i < NREQ; i++) load(i, 'h40 * i, 8);
      repeat (27) tick();
      n = 0;
      foreach (wcyc[k]) if (wcyc[k] >= s + 2 && wcyc[k] <= s + 26) n++;
      check("t3_writes_in_25", n, 20);
      for (int k = 0; k < 20; k++)
         check("t3_order", k < wlog.size() ? wlog[k] : 'x, 'h40 * ((k / 4) % 4) + (k / 16) * 4 + k % 4);
      run_idle(200);

      do_reset();
      load(2, 'h80, 6); load(3, 'hC0, 2);
      repeat (3) tick();
      almost_full_flag = 1'b1;
      repeat (5) begin
         @(negedge w_clk);
         check("t4_stall_ack", ack, 0);
         check("t4_stall_grant", grant, 4'b0100);
         tick();
      end
      almost_full_flag = 1'b0;
      for (int b = 0; b < 10; b++) begin
         @(negedge w_clk);
         if (grant !== 4'b0100) break;
         tick();
      end
      check("t4_burst_words", q[2].size(), 2);
      check("t4_release", grant, 0);
      tick(); @(negedge w_clk); check("t4_next_owner", grant, 4'b1000);
      run_idle(100);

      do_reset();
      load(2, 'h77, 2);
      tick();
      f_flag = 1'b1;
      @(negedge w_clk); check("t5_full_ack", ack, 0);
      tick();
      q[2].delete(); drive();
      @(negedge w_clk); check("t5_stall_grant", grant, 4'b0100); check("t5_drop_ack", ack, 0);
      tick();
      f_flag = 1'b0;
      @(negedge w_clk); check("t5_idle_grant", grant, 0); check("t5_no_write", valid_write, 0);
      load(0, 'h01, 1); load(3, 'h03, 1);
      tick(); @(negedge w_clk); check("t5_rr_ptr", grant, 4'b1000);
      run_idle(100);
      hits = 0;
      foreach (wlog[k]) if (wlog[k] == 'h77) hits++;
      check("t5_dropped_word", hits, 0);

      do_reset();
      load(3, 'hD0, 4);
      repeat (3) tick();
      n_rst = 1'b0;
      @(negedge w_clk); check("t6_rst_ack", ack, 0);
      tick();
      n_rst = 1'b1;
      load(0, 'hE0, 1);
      @(negedge w_clk);
      check("t6_no_write", valid_write, 0); check("t6_grant_clr", grant, 0); check("t6_word_kept", q[3].size(), 2);
      tick(); @(negedge w_clk); check("t6_restart", grant, 4'b0001);
      run_idle(100);

      repeat (3000) begin
         tick();
         n_rst = $urandom_range(0, 99) != 0;
         almost_full_flag = $urandom_range(0, 4) == 0;
         f_flag = $urandom_range(0, 19) == 0;
         for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 6)) q[i].push_back(SIZE'($urandom));
            if ($urandom_range(0, 49) == 0) q[i].delete();
         end
         drive();
      end
      n_rst = 1'b1; f_flag = 1'b0; almost_full_flag = 1'b0;
      run_idle(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
